// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its scrub controller.
package reg_file_pkg;

  typedef enum logic {SCRUB, RUN} state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int MAX_ADDR_WIDTH     = 32;

  // Callers zero-extend their selects so one helper serves every address width.
  function automatic logic sel_match(input logic [MAX_ADDR_WIDTH-1:0] a,
                                     input logic [MAX_ADDR_WIDTH-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/reg_file_scrub_ctrl.sv
// Scrub sequencer: after reset, walks every entry once and then holds the file in RUN.
module reg_file_scrub_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  output logic                  scrub_en,
  output logic [ADDR_WIDTH-1:0] scrub_idx
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == SCRUB) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = RUN;
      end
    end
    ready_d = (state_d == RUN);
  end

  // Reset parks the index at 0, so a held reset never advances the scrub.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCRUB;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign scrub_en  = (state_q == SCRUB);
  assign scrub_idx = idx_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with prioritised writes, optional bypass,
// optional hardwired-zero entry 0 and a reset-triggered scrub.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter bit BYPASS      = 1'b1,
  parameter bit ZERO_REG    = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WRITE_PORTS-1:0]            write,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_sel,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_sel,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data,
  output logic                              ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  scrub_en;
  logic [ADDR_WIDTH-1:0] scrub_idx;
  logic                  user_wr_ok;
  logic [ADDR_WIDTH-1:0] rsel [READ_PORTS];
  logic [DATA_WIDTH-1:0] rval [READ_PORTS];

  reg_file_scrub_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scrub_ctrl (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .scrub_en (scrub_en),
    .scrub_idx(scrub_idx)
  );

  // A write presented while reset is sampled high must not land.
  assign user_wr_ok = ready && !reset;

  // Ascending port order lets the highest-numbered matching port win.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      if (user_wr_ok && !(ZERO_REG && e == 0)) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (write[p] &&
              sel_match(MAX_ADDR_WIDTH'(write_sel[p*ADDR_WIDTH +: ADDR_WIDTH]),
                        MAX_ADDR_WIDTH'(e))) begin
            mem_d[e] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
    if (scrub_en) begin
      mem_d[scrub_idx] = '0;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    read_data = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      rsel[r] = read_sel[r*ADDR_WIDTH +: ADDR_WIDTH];
      rval[r] = mem_q[rsel[r]];
      if (BYPASS && user_wr_ok) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (write[p] &&
              sel_match(MAX_ADDR_WIDTH'(write_sel[p*ADDR_WIDTH +: ADDR_WIDTH]),
                        MAX_ADDR_WIDTH'(rsel[r]))) begin
            rval[r] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      // Zero entry and scrub masking override any bypass hit.
      if ((ZERO_REG && rsel[r] == '0) || !ready) begin
        rval[r] = '0;
      end
      read_data[r*DATA_WIDTH +: DATA_WIDTH] = rval[r];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: one bypassing and one non-bypassing instance
// share stimulus and are compared each cycle against a behavioural model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NW-1:0]    write = '0;
  logic [NW*AW-1:0] write_sel = '0;
  logic [NW*DW-1:0] write_data = '0;
  logic [NR*AW-1:0] read_sel = '0;
  logic [NR*DW-1:0] rd_byp, rd_nb;
  logic             ready_byp, ready_nb;

  int checks = 0;
  int passes = 0;

  logic [31:0] m_mem [DEPTH];
  logic        m_ready = 1'b0;
  int          scrub_left = DEPTH;

  always #5 clock = ~clock;

  reg_file_mp dut (
    .clock     (clock),
    .reset     (reset),
    .write     (write),
    .write_sel (write_sel),
    .write_data(write_data),
    .read_sel  (read_sel),
    .read_data (rd_byp),
    .ready     (ready_byp)
  );

  reg_file_mp #(.BYPASS(1'b0)) dut_nb (
    .clock     (clock),
    .reset     (reset),
    .write     (write),
    .write_sel (write_sel),
    .write_data(write_data),
    .read_sel  (read_sel),
    .read_data (rd_nb),
    .ready     (ready_nb)
  );

  // Reference: scrub is a countdown of DEPTH idle edges that wipes the whole file at the end.
  always @(posedge clock) begin
    if (reset) begin
      m_ready    <= 1'b0;
      scrub_left <= DEPTH;
    end else if (!m_ready) begin
      scrub_left <= scrub_left - 1;
      if (scrub_left == 1) begin
        m_ready <= 1'b1;
        foreach (m_mem[i]) m_mem[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (write[p] && write_sel[p*AW +: AW] != 0) begin
          m_mem[write_sel[p*AW +: AW]] <= write_data[p*DW +: DW];
        end
      end
    end
  end

  function automatic logic [31:0] expRead(input int port, input bit byp);
    logic [4:0]  s;
    logic [31:0] v;
    s = read_sel[port*AW +: AW];
    if (!m_ready || s == 0) return '0;
    v = m_mem[s];
    if (byp && !reset) begin
      for (int p = 0; p < NW; p++) begin
        if (write[p] && write_sel[p*AW +: AW] == s) v = write_data[p*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic checkAll();
    for (int r = 0; r < NR; r++) begin
      checkOutput($sformatf("rd%0d_byp", r), rd_byp[r*DW +: DW], expRead(r, 1'b1));
      checkOutput($sformatf("rd%0d_nobyp", r), rd_nb[r*DW +: DW], expRead(r, 1'b0));
    end
    checkOutput("ready_byp", {31'b0, ready_byp}, {31'b0, m_ready});
    checkOutput("ready_nobyp", {31'b0, ready_nb}, {31'b0, m_ready});
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then step past the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] w,
                               input logic [4:0] ws0, input logic [4:0] ws1,
                               input logic [31:0] wd0, input logic [31:0] wd1,
                               input logic [4:0] rs0, input logic [4:0] rs1);
    reset      = rst;
    write      = w;
    write_sel  = {ws1, ws0};
    write_data = {wd1, wd0};
    read_sel   = {rs1, rs0};
    @(negedge clock);
    checkAll();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [4:0] rs0, input logic [4:0] rs1);
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, rs0, rs1);
  endtask

  task automatic waitScrub(input string tag, input int expected_len);
    int n = 0;
    while (ready_byp !== 1'b1 && n < 100) begin
      idle(5'd0, 5'd0);
      n++;
    end
    checkOutput(tag, 32'(n), 32'(expected_len));
  endtask

  initial begin
    logic       rst;
    logic [1:0] w;
    logic [4:0] ws0, ws1, rs0, rs1;

    @(posedge clock);
    #1;
    waitScrub("initial_scrub_len", DEPTH);

    // Basic write then read on two independent ports.
    applyStimulus(1'b0, 2'b01, 5'd1, 5'd0, 32'h2, 32'h0, 5'd0, 5'd0);
    applyStimulus(1'b0, 2'b01, 5'd3, 5'd0, 32'h5, 32'h0, 5'd0, 5'd0);
    applyStimulus(1'b0, 2'b01, 5'd7, 5'd0, 32'h9, 32'h0, 5'd0, 5'd0);
    idle(5'd7, 5'd3);
    checkOutput("basic_p0", rd_byp[31:0], 32'h9);
    checkOutput("basic_p1", rd_byp[63:32], 32'h5);
    idle(5'd3, 5'd1);
    checkOutput("basic2_p0", rd_byp[31:0], 32'h5);
    checkOutput("basic2_p1", rd_nb[63:32], 32'h2);

    // Entry 0 is hardwired, including its bypass path.
    applyStimulus(1'b0, 2'b01, 5'd0, 5'd0, 32'h7, 32'h0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    checkOutput("zero_p0", rd_byp[31:0], 32'h0);
    checkOutput("zero_p1", rd_nb[63:32], 32'h0);

    applyStimulus(1'b0, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 5'd0, 5'd0);
    idle(5'd5, 5'd5);
    checkOutput("conflict_byp", rd_byp[31:0], 32'h22);
    checkOutput("conflict_nobyp", rd_nb[63:32], 32'h22);

    applyStimulus(1'b0, 2'b01, 5'd9, 5'd0, 32'hDEADBEEF, 32'h0, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    checkOutput("bypass_next_nobyp", rd_nb[31:0], 32'hDEADBEEF);

    // Preloaded data and a write issued during the scrub must both end up cleared.
    applyStimulus(1'b0, 2'b01, 5'd5, 5'd0, 32'hA, 32'h0, 5'd5, 5'd5);
    applyStimulus(1'b1, 2'b01, 5'd6, 5'd0, 32'h55, 32'h0, 5'd5, 5'd5);
    applyStimulus(1'b0, 2'b01, 5'd6, 5'd0, 32'h77, 32'h0, 5'd5, 5'd6);
    waitScrub("pulse_scrub_len", DEPTH - 1);
    idle(5'd5, 5'd6);
    checkOutput("scrubbed_e5", rd_byp[31:0], 32'h0);
    checkOutput("scrubbed_e6", rd_byp[63:32], 32'h0);

    applyStimulus(1'b0, 2'b01, 5'd12, 5'd0, 32'h1234, 32'h0, 5'd0, 5'd0);
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
    for (int i = 0; i < 10; i++) idle(5'd12, 5'd0);
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
    waitScrub("midscrub_len", DEPTH);
    idle(5'd12, 5'd0);
    checkOutput("midscrub_e12", rd_byp[31:0], 32'h0);

    // Random traffic, biased toward address collisions, with rare resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      w   = 2'($urandom_range(0, 3));
      ws0 = 5'($urandom_range(0, 31));
      ws1 = ($urandom_range(0, 3) == 0) ? ws0 : 5'($urandom_range(0, 31));
      rs0 = ($urandom_range(0, 2) == 0) ? ws0 : 5'($urandom_range(0, 31));
      rs1 = ($urandom_range(0, 2) == 0) ? ws1 : 5'($urandom_range(0, 31));
      applyStimulus(rst, w, ws0, ws1, $urandom, $urandom, rs0, rs1);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
